// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// one or two stop bits, each bit held for CLKS_PER_BIT clocks.
module uart_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_ena,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [CW-1:0]     baud_q, baud_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Payload registers carry no reset: they are only read after a fresh load.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bit_end = (baud_q == BAUD_MAX);

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_ena) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ ODD_BIT;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: five parameterisations, table vectors,
// hand-written corner sequences and randomized frames against a frame model.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ena_w;
  logic [15:0] data_r [5];
  logic [4:0]  tx_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;

  int cfg_dw  [5] = '{8, 8, 8, 5, 7};
  int cfg_cpb [5] = '{4, 4, 4, 1, 3};
  int cfg_pen [5] = '{0, 1, 1, 0, 1};
  int cfg_podd[5] = '{0, 0, 1, 0, 1};
  int cfg_sb  [5] = '{1, 1, 1, 2, 2};

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_ena(ena_w[0]), .tx_data(data_r[0][7:0]),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_ena(ena_w[1]), .tx_data(data_r[1][7:0]),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_ena(ena_w[2]), .tx_data(data_r[2][7:0]),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_frame #(.DATA_W(5), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_ena(ena_w[3]), .tx_data(data_r[3][4:0]),
    .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));
  uart_tx_frame #(.DATA_W(7), .CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u4 (
    .clk(clk), .rst(rst), .tx_ena(ena_w[4]), .tx_data(data_r[4][6:0]),
    .tx(tx_w[4]), .tx_busy(busy_w[4]), .tx_done(done_w[4]));

  typedef struct {
    int          inst;
    logic [15:0] data;
    logic [31:0] bits;   // bit k = k-th serial bit, start bit first
    int          nbits;
  } vec_t;

  task automatic chk(input string name, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got %b expected %b at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Expected serial sequence derived from the framing rules.
  task automatic model_frame(input int inst, input logic [15:0] d,
                             output logic [31:0] bits, output int n);
    int ones;
    int k;
    bits = '0;
    ones = 0;
    k = 1;
    for (int i = 0; i < cfg_dw[inst]; i++) begin
      bits[k] = d[i];
      if (d[i]) ones++;
      k++;
    end
    if (cfg_pen[inst] != 0) begin
      bits[k] = ((ones % 2) != cfg_podd[inst]);
      k++;
    end
    for (int s = 0; s < cfg_sb[inst]; s++) begin
      bits[k] = 1'b1;
      k++;
    end
    n = k;
  endtask

  // Called just after the accepting edge; ends at the tx_done cycle.
  task automatic check_frame(input int inst, input logic [31:0] bits, input int n);
    int cpb;
    cpb = cfg_cpb[inst];
    for (int c = 0; c < n * cpb; c++) begin
      @(negedge clk);
      chk("tx_bit", inst, tx_w[inst], bits[c / cpb]);
      chk("busy_in_frame", inst, busy_w[inst], 1'b1);
      chk("done_in_frame", inst, done_w[inst], 1'b0);
    end
    @(negedge clk);
    chk("tx_after_frame", inst, tx_w[inst], 1'b1);
    chk("busy_after_frame", inst, busy_w[inst], 1'b0);
    chk("done_pulse", inst, done_w[inst], 1'b1);
  endtask

  task automatic send(input int inst, input logic [15:0] d);
    @(negedge clk);
    data_r[inst] = d;
    ena_w[inst]  = 1'b1;
    @(posedge clk);
    #1;
    ena_w[inst]  = 1'b0;
    data_r[inst] = 16'($urandom);
  endtask

  task automatic check_idle(input int inst);
    @(negedge clk);
    chk("idle_tx", inst, tx_w[inst], 1'b1);
    chk("idle_busy", inst, busy_w[inst], 1'b0);
    chk("idle_done", inst, done_w[inst], 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    logic [31:0] bits;
    int          n;
    int          inst;
    logic [15:0] d;

    vecs[0] = '{0, 16'h00A5, 32'h0000034A, 10};
    vecs[1] = '{1, 16'h00A5, 32'h0000054A, 11};
    vecs[2] = '{2, 16'h00A5, 32'h0000074A, 11};
    vecs[3] = '{1, 16'h0001, 32'h00000602, 11};
    vecs[4] = '{3, 16'h001F, 32'h000000FE, 8};

    rst   = 1'b1;
    ena_w = '0;
    for (int i = 0; i < 5; i++) data_r[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("reset_tx", i, tx_w[i], 1'b1);
      chk("reset_busy", i, busy_w[i], 1'b0);
      chk("reset_done", i, done_w[i], 1'b0);
    end
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      send(vecs[v].inst, vecs[v].data);
      check_frame(vecs[v].inst, vecs[v].bits, vecs[v].nbits);
      check_idle(vecs[v].inst);
    end

    // Held request with data changing mid-frame.
    @(negedge clk);
    data_r[0] = 16'h005A;
    ena_w[0]  = 1'b1;
    @(posedge clk);
    #1;
    data_r[0] = 16'h00C3;
    model_frame(0, 16'h005A, bits, n);
    check_frame(0, bits, n);
    @(posedge clk);
    #1;
    data_r[0] = 16'h000F;
    ena_w[0]  = 1'b0;
    model_frame(0, 16'h00C3, bits, n);
    check_frame(0, bits, n);
    check_idle(0);

    // Reset during data bit 3.
    send(0, 16'h003C);
    repeat (17) @(negedge clk);
    chk("pre_reset_busy", 0, busy_w[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_tx", 0, tx_w[0], 1'b1);
    chk("midreset_busy", 0, busy_w[0], 1'b0);
    chk("midreset_done", 0, done_w[0], 1'b0);
    rst = 1'b0;
    send(0, 16'h0096);
    model_frame(0, 16'h0096, bits, n);
    check_frame(0, bits, n);
    check_idle(0);

    // rst and tx_ena together while idle.
    @(negedge clk);
    rst       = 1'b1;
    ena_w[1]  = 1'b1;
    data_r[1] = 16'h0000;
    @(negedge clk);
    chk("rst_ena_tx", 1, tx_w[1], 1'b1);
    chk("rst_ena_busy", 1, busy_w[1], 1'b0);
    rst      = 1'b0;
    ena_w[1] = 1'b0;
    check_idle(1);

    for (int r = 0; r < 40; r++) begin
      inst = int'($urandom_range(0, 4));
      d    = 16'($urandom) & 16'((1 << cfg_dw[inst]) - 1);
      send(inst, d);
      model_frame(inst, d, bits, n);
      check_frame(inst, bits, n);
      check_idle(inst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
